// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: PWM line in, decoded duty sample and link status out
interface pwm_duty_decoder_if #(
    parameter int PWMSIZE = 8
);
    logic               PwmIn;
    logic [PWMSIZE-1:0] Sample;
    logic               SampleValid;
    logic               Locked;
    logic               SyncErr;
    modport master (output PwmIn, input Sample, SampleValid, Locked, SyncErr);
    modport slave  (input PwmIn, output Sample, SampleValid, Locked, SyncErr);
endinterface

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the per-frame high-cycle count of a frame-aligned PWM input
module pwm_duty_decoder #(
    parameter int PWMSIZE     = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic               Clock,
    input logic               Reset,
    pwm_duty_decoder_if.slave pwm_io
);
    typedef enum logic {HUNT, MEASURE} state_t;
    localparam logic [PWMSIZE-1:0] LAST = '1;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PWMSIZE-1:0]     frame_pos_q, frame_pos_d;
    logic [PWMSIZE:0]       high_cnt_q, high_cnt_d;
    logic                   aligned_q;
    logic [PWMSIZE-1:0]     sample_q;
    logic                   valid_q, locked_q, sync_err_q;
    logic                   s, rise, at_last;
    logic [PWMSIZE-1:0]     sat;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_io.PwmIn};
            prev_q <= s;
        end
    end
    // high_cnt_d never exceeds FRAME, so its top bit alone signals saturation
    always_comb begin
        s           = sync_q[SYNC_STAGES-1];
        rise        = s & ~prev_q;
        at_last     = frame_pos_q == LAST;
        frame_pos_d = frame_pos_q + PWMSIZE'(1);
        high_cnt_d  = high_cnt_q + (PWMSIZE+1)'(s);
        sat         = high_cnt_d[PWMSIZE] ? LAST : high_cnt_d[PWMSIZE-1:0];
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= HUNT;
            frame_pos_q <= '0;
            high_cnt_q  <= '0;
            aligned_q   <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_pos_q <= frame_pos_d;
            high_cnt_q  <= high_cnt_d;
            if (state_q == HUNT) begin
                if (rise) begin
                    state_q     <= MEASURE;
                    frame_pos_q <= PWMSIZE'(1);
                    high_cnt_q  <= (PWMSIZE+1)'(1);
                    aligned_q   <= 1'b1;
                end else if (at_last) begin
                    state_q     <= MEASURE;
                    frame_pos_q <= '0;
                    high_cnt_q  <= '0;
                    aligned_q   <= 1'b0;
                end
            end else if (rise && frame_pos_q != '0) begin
                sync_err_q  <= 1'b1;
                locked_q    <= 1'b0;
                frame_pos_q <= PWMSIZE'(1);
                high_cnt_q  <= (PWMSIZE+1)'(1);
                aligned_q   <= 1'b1;
            end else if (at_last) begin
                sample_q   <= sat;
                valid_q    <= 1'b1;
                locked_q   <= locked_q | aligned_q;
                high_cnt_q <= '0;
                aligned_q  <= 1'b0;
            end else if (rise) begin
                aligned_q <= 1'b1;
            end
        end
    end
    assign pwm_io.Sample      = sample_q;
    assign pwm_io.SampleValid = valid_q;
    assign pwm_io.Locked      = locked_q;
    assign pwm_io.SyncErr     = sync_err_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: frame generator with queued expected samples and a decoupled monitor
module tb_pwm_duty_decoder;
    typedef struct {
        int sample;
        bit locked;
        int period;
    } exp_t;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid = 0;
    int   exp_err = 0;
    int   seen_err = 0;
    bit   lock_m = 1'b0;
    bit   have_prev = 1'b0;
    exp_t sb[$];
    pwm_duty_decoder_if #(.PWMSIZE(8)) bus ();
    pwm_duty_decoder #(.PWMSIZE(8), .SYNC_STAGES(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .pwm_io(bus)
    );
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && bus.SyncErr) begin
            seen_err++;
            chk("locked_on_syncerr", int'(bus.Locked), 0);
        end
        if (!Reset && bus.SampleValid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_sample got %0d expected none at cycle %0d", bus.Sample, cyc);
            end else begin
                e = sb.pop_front();
                chk("sample", int'(bus.Sample), e.sample);
                chk("locked", int'(bus.Locked), int'(e.locked));
                if (e.period != 0) chk("period", cyc - last_valid, e.period);
            end
            last_valid = cyc;
        end
    end
    task automatic do_reset(input logic level);
        @(negedge Clock);
        Reset = 1'b1;
        bus.PwmIn = level;
        repeat (3) @(negedge Clock);
        sb.delete();
        have_prev = 1'b0;
        lock_m = 1'b0;
        Reset = 1'b0;
    endtask
    task automatic send_frame(input int duty, input int gap);
        exp_t e;
        for (int i = 0; i < gap; i++) begin
            @(negedge Clock);
            bus.PwmIn = 1'b0;
        end
        if (gap != 0) begin
            exp_err++;
            lock_m = 1'b0;
        end
        lock_m = lock_m | (duty != 0);
        e.sample = duty;
        e.locked = lock_m;
        e.period = have_prev ? 256 + gap : 0;
        sb.push_back(e);
        have_prev = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge Clock);
            bus.PwmIn = (i < duty);
        end
    endtask
    task automatic frame_then_reset(input int duty, input int pos);
        for (int i = 0; i < pos; i++) begin
            @(negedge Clock);
            bus.PwmIn = (i < duty);
        end
        chk("locked_before_reset", int'(bus.Locked), 1);
        @(negedge Clock);
        Reset = 1'b1;
        bus.PwmIn = 1'b0;
        @(posedge Clock);
        #1;
        chk("rst_sample", int'(bus.Sample), 0);
        chk("rst_valid", int'(bus.SampleValid), 0);
        chk("rst_locked", int'(bus.Locked), 0);
        chk("rst_syncerr", int'(bus.SyncErr), 0);
        @(negedge Clock);
        sb.delete();
        have_prev = 1'b0;
        lock_m = 1'b0;
        Reset = 1'b0;
    endtask
    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge Clock);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask
    task automatic push_held(input int sample, input bit locked);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.sample = sample;
            e.locked = locked;
            e.period = (i == 0) ? 0 : 256;
            sb.push_back(e);
        end
    endtask
    initial begin
        int duty, gap;
        bus.PwmIn = 1'b0;
        repeat (3) @(negedge Clock);
        chk("init_sample", int'(bus.Sample), 0);
        chk("init_valid", int'(bus.SampleValid), 0);
        chk("init_locked", int'(bus.Locked), 0);
        chk("init_syncerr", int'(bus.SyncErr), 0);
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) send_frame(8'h80, 0);
        drain("drain_half", 40);
        do_reset(1'b0);
        send_frame(255, 0); send_frame(1, 0); send_frame(255, 0);
        send_frame(1, 0);   send_frame(0, 0); send_frame(255, 0);
        drain("drain_extremes", 40);
        do_reset(1'b0);
        send_frame(8'h10, 0); send_frame(8'h10, 0);
        send_frame(8'hC0, 0); send_frame(8'hC0, 0);
        drain("drain_step", 40);
        do_reset(1'b0);
        send_frame(8'h40, 0); send_frame(8'h40, 0);
        send_frame(8'h40, 37);
        send_frame(8'h40, 0); send_frame(8'h40, 0);
        drain("drain_phase_jump", 40);
        do_reset(1'b0);
        send_frame(8'h40, 0); send_frame(8'h40, 0);
        frame_then_reset(8'h40, 100);
        send_frame(8'h40, 0); send_frame(8'h40, 0); send_frame(8'h40, 0);
        drain("drain_mid_reset", 40);
        do_reset(1'b0);
        send_frame($urandom_range(255, 1), 0);
        for (int i = 0; i < 40; i++) begin
            gap  = ($urandom_range(9) == 0) ? $urandom_range(255, 1) : 0;
            duty = (gap != 0 || $urandom_range(7) != 0) ? $urandom_range(255, 1) : 0;
            send_frame(duty, gap);
        end
        drain("drain_random", 40);
        do_reset(1'b0);
        push_held(0, 1'b0);
        drain("drain_held_low", 1400);
        do_reset(1'b1);
        push_held(255, 1'b1);
        drain("drain_held_high", 1200);
        do_reset(1'b0);
        chk("syncerr_count", seen_err, exp_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
